// File: rtl/product_accumulator.sv
// Batch accumulator for the signed multiplier's product stream: sums `len` products into a
// wide accumulator and pulses acc_valid at the end. Define ACC_SATURATE_EN to clamp on overflow.
module product_accumulator #(
    parameter int PROD_W = 64,
    parameter int ACC_W  = 72,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  acc,
    output logic              acc_valid,
    output logic              busy,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]               state, state_nxt;
    logic [CNT_W-1:0]         len_q;
    logic [CNT_W-1:0]         count_inc;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_s;
    logic signed [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]         acc_add;
    logic                     add_ovf;
    logic                     xfer;

    assign prod_s     = prod;
    assign prod_ext   = ACC_W'(prod_s);
    assign acc_s      = acc;
    assign sum        = acc_s + prod_ext;
    assign count_inc  = count + 1'b1;
    assign prod_ready = (state == ACCUM) && en;
    assign xfer       = prod_ready && prod_valid;
    assign busy       = (state != IDLE);

    // Overflow only when both operands share a sign and the result's sign differs.
    assign add_ovf = (acc_s[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_s[ACC_W-1]);

`ifdef ACC_SATURATE_EN
    always_comb begin
        acc_add = sum;
        if (add_ovf)
            acc_add = acc_s[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`else
    assign acc_add = sum;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len == '0) ? DONE : ACCUM;
            ACCUM:   if (xfer && (count_inc == len_q)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            acc       <= '0;
            acc_valid <= 1'b0;
            count     <= '0;
            overflow  <= 1'b0;
            len_q     <= '0;
        end else if (en) begin
            state     <= state_nxt;
            acc_valid <= (state_nxt == DONE);
            if ((state == IDLE) && start) begin
                acc      <= '0;
                count    <= '0;
                overflow <= 1'b0;
                len_q    <= len;
            end else if (xfer) begin
                acc   <= acc_add;
                count <= count_inc;
                if (add_ovf)
                    overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: two instances (ACC_W=72 default and ACC_W=64) share stimulus;
// vector table, hand sequences, and randomized batches against an arithmetic reference model.
module tb_product_accumulator;

    localparam int PW  = 64;
    localparam int CW  = 8;
    localparam int AW  = 72;
    localparam int AW2 = 64;
`ifdef ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, en, start, prod_valid;
    logic [CW-1:0] len;
    logic [PW-1:0] prod;

    logic pr_a, av_a, busy_a, ov_a;
    logic signed [AW-1:0] acc_a;
    logic [CW-1:0] cnt_a;
    logic pr_b, av_b, busy_b, ov_b;
    logic signed [AW2-1:0] acc_b;
    logic [CW-1:0] cnt_b;

    int checks = 0;
    int failures = 0;

    logic signed [127:0] m_a, m_b;
    bit o_a, o_b;
    int m_cnt;

    always #5 clk = ~clk;

    product_accumulator dut (
        .clk(clk), .reset(reset), .en(en), .start(start), .len(len), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(pr_a), .acc(acc_a), .acc_valid(av_a),
        .busy(busy_a), .count(cnt_a), .overflow(ov_a)
    );

    product_accumulator #(.ACC_W(AW2)) dut64 (
        .clk(clk), .reset(reset), .en(en), .start(start), .len(len), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(pr_b), .acc(acc_b), .acc_valid(av_b),
        .busy(busy_b), .count(cnt_b), .overflow(ov_b)
    );

    typedef struct {
        string               name;
        int unsigned         n;
        logic [3:0][63:0]    p;
        logic signed [127:0] e72;
        logic signed [127:0] e64;
        bit                  ov64;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic signed [127:0] act, input logic signed [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Reference: exact add, then wrap or clamp into a w-bit signed range.
    function automatic void madd(input int w, input logic signed [63:0] p,
                                 inout logic signed [127:0] a, inout bit ov);
        logic signed [127:0] s, hi, lo, span;
        span = 128'sd1 <<< w;
        hi   = (span >>> 1) - 1;
        lo   = -(span >>> 1);
        s    = a + p;
        if (s > hi || s < lo) begin
            ov = 1'b1;
            if (SAT) s = (s > hi) ? hi : lo;
            else if (s > hi) s = s - span;
            else s = s + span;
        end
        a = s;
    endfunction

    function automatic void setv(input int i, input string nm, input int unsigned n,
                                 input logic signed [63:0] p0, input logic signed [63:0] p1,
                                 input logic signed [63:0] p2, input logic signed [127:0] e72,
                                 input logic signed [127:0] e64, input bit ov);
        tbl[i].name = nm;
        tbl[i].n    = n;
        tbl[i].p[0] = p0;
        tbl[i].p[1] = p1;
        tbl[i].p[2] = p2;
        tbl[i].p[3] = '0;
        tbl[i].e72  = e72;
        tbl[i].e64  = e64;
        tbl[i].ov64 = ov;
    endfunction

    task automatic check_model(input string nm);
        chk({nm, "_acc72"}, acc_a, m_a);
        chk({nm, "_acc64"}, acc_b, m_b);
        chk({nm, "_count"}, cnt_a, m_cnt);
        chk({nm, "_count64"}, cnt_b, m_cnt);
        chk({nm, "_ovf72"}, ov_a, o_a);
        chk({nm, "_ovf64"}, ov_b, o_b);
    endtask

    // Applies a table entry with every product valid; returns with the DUT in DONE.
    task automatic apply_vec(input vec_t v);
        en = 1'b1; start = 1'b1; len = CW'(v.n); prod_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int unsigned i = 0; i < v.n; i++) begin
            prod = v.p[i]; prod_valid = 1'b1;
            tick();
        end
        prod_valid = 1'b0;
        chk({v.name, "_acc72"}, acc_a, v.e72);
        chk({v.name, "_acc64"}, acc_b, v.e64);
        chk({v.name, "_ovf72"}, ov_a, 0);
        chk({v.name, "_ovf64"}, ov_b, v.ov64);
        chk({v.name, "_count"}, cnt_a, v.n);
        chk({v.name, "_acc_valid"}, av_a, 1);
    endtask

    task automatic run_batch(input int L, input bit stall);
        int budget;
        logic signed [63:0] p;
        en = 1'b1; start = 1'b1; len = CW'(L); prod_valid = 1'b0;
        tick();
        start = 1'b0;
        m_a = 0; m_b = 0; o_a = 0; o_b = 0; m_cnt = 0;
        chk("rb_start_busy", busy_a, 1);
        check_model("rb_start");
        budget = 0;
        while (m_cnt < L && budget < 4000) begin
            en         = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            prod_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            start      = ($urandom_range(0, 7) == 0);
            len        = CW'($urandom());
            p          = rand64();
            prod       = p;
            #1;
            chk("rb_prod_ready", pr_a, en);
            chk("rb_prod_ready64", pr_b, en);
            tick();
            if (en && prod_valid) begin
                madd(AW, p, m_a, o_a);
                madd(AW2, p, m_b, o_b);
                m_cnt++;
            end
            chk("rb_acc_valid", av_a, (m_cnt == L));
            check_model("rb_step");
            budget++;
        end
        if (m_cnt < L) chk("rb_timeout", 0, 1);
        start = 1'b0; prod_valid = 1'b0; en = 1'b1;
        chk("rb_done_pulse", av_a, 1);
        chk("rb_done_pulse64", av_b, 1);
        check_model("rb_done");
        en = 1'b0;
        tick();
        chk("rb_en0_hold_valid", av_a, 1);
        chk("rb_en0_hold_busy", busy_a, 1);
        en = 1'b1;
        tick();
        chk("rb_idle_valid", av_a, 0);
        chk("rb_idle_busy", busy_a, 0);
        check_model("rb_idle");
    endtask

    initial begin
        setv(0, "basic", 3, 64'sd464960160, -64'sd143362716, 64'sd1348760118,
             128'sd1670357562, 128'sd1670357562, 1'b0);
        setv(1, "pair", 2, -64'sd1617244718460915990, 64'sd67081, 64'sd0,
             -128'sd1617244718460848909, -128'sd1617244718460848909, 1'b0);
        setv(2, "ovf_pos", 2, 64'sh7FFF_FFFF_FFFF_FFFF, 64'sh7FFF_FFFF_FFFF_FFFF, 64'sd0,
             128'sd18446744073709551614,
             SAT ? 128'sd9223372036854775807 : -128'sd2, 1'b1);
        setv(3, "ovf_neg", 2, 64'sh8000_0000_0000_0000, 64'sh8000_0000_0000_0000, 64'sd0,
             -128'sd18446744073709551616,
             SAT ? -128'sd9223372036854775808 : 128'sd0, 1'b1);
        setv(4, "single", 1, -64'sd5, 64'sd0, 64'sd0, -128'sd5, -128'sd5, 1'b0);

        reset = 1'b0; en = 1'b0; start = 1'b0; len = '0; prod = '0; prod_valid = 1'b0;
        #1;
        chk("rst_acc", acc_a, 0);
        chk("rst_count", cnt_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_valid", av_a, 0);
        chk("rst_ovf", ov_a, 0);
        chk("rst_ready", pr_a, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        en = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            apply_vec(tbl[i]);
            tick();
            chk("vec_idle_busy", busy_a, 0);
        end

        // Overflow clears on the next start.
        apply_vec(tbl[2]);
        tick();
        chk("ovf_held_idle", ov_b, 1);
        start = 1'b1; len = 8'd1;
        tick();
        start = 1'b0;
        chk("ovf_cleared", ov_b, 0);
        chk("ovf_cleared_acc", acc_b, 0);
        prod = 64'd7; prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
        chk("ovf_clr_acc", acc_b, 7);
        tick();

        // Reset mid-batch after two transfers.
        start = 1'b1; len = 8'd5;
        tick();
        start = 1'b0; prod = 64'd11; prod_valid = 1'b1;
        tick();
        tick();
        chk("pre_rst_count", cnt_a, 2);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_acc", acc_a, 0);
        chk("midrst_count", cnt_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_ready", pr_a, 0);
        chk("midrst_valid", av_a, 0);
        prod_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("post_rst_busy", busy_a, 0);

        // Stall: valid gaps and en=0 cycles accept nothing.
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0;
        prod = -64'sd1617244718460915990; prod_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready", pr_a, 1);
            tick();
            chk("stall_gap_count", cnt_a, 0);
        end
        prod_valid = 1'b1;
        tick();
        chk("stall_count1", cnt_a, 1);
        prod = 64'sd67081; en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stall_en0_ready", pr_a, 0);
            tick();
            chk("stall_en0_count", cnt_a, 1);
        end
        en = 1'b1;
        tick();
        prod_valid = 1'b0;
        chk("stall_acc", acc_a, -128'sd1617244718460848909);
        chk("stall_count2", cnt_a, 2);
        chk("stall_valid", av_a, 1);
        tick();

        // Empty batch, then back-to-back start right after the pulse.
        start = 1'b1; len = 8'd0;
        tick();
        start = 1'b0;
        chk("empty_valid", av_a, 1);
        chk("empty_acc", acc_a, 0);
        chk("empty_count", cnt_a, 0);
        tick();
        chk("empty_idle_valid", av_a, 0);
        apply_vec(tbl[0]);
        tick();
        chk("b2b_hold_acc", acc_a, 128'sd1670357562);
        chk("b2b_hold_valid", av_a, 0);
        start = 1'b1; len = 8'd1;
        tick();
        start = 1'b0;
        chk("b2b_start_acc", acc_a, 0);
        prod = '0; prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
        chk("b2b_valid", av_a, 1);
        chk("b2b_acc", acc_a, 0);
        tick();

        for (int k = 0; k < 30; k++)
            run_batch((k == 0) ? 0 : int'($urandom_range(0, 6)), 1'b1);
        run_batch(255, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
Downstream consumer of the 32x32 signed multiplier's 64-bit product stream. It accumulates a programmed batch of signed products into a wide accumulator using a valid/ready handshake, then presents the sum for one cycle. It is used for dot-product and MAC checks on top of the multiplier family, and has a sticky overflow flag.

Parameters:
PROD_W, 64, signed product width (matches multiplier result)
ACC_W, 72, signed accumulator width; must be >= PROD_W
CNT_W, 8, batch-length and counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
en  in  1  clock enable; 0 freezes all state
start  in  1  begin batch (sampled only in IDLE with en=1)
len  in  CNT_W  number of products in batch, latched on start
prod  in  PROD_W  signed product from multiplier
prod_valid  in  1  prod is valid this cycle
prod_ready  out  1  block accepts prod this cycle
acc  out  ACC_W  signed accumulated sum
acc_valid  out  1  one-cycle pulse: acc holds final batch sum
busy  out  1  state != IDLE
count  out  CNT_W  products accepted in current batch
overflow  out  1  sticky signed overflow in current batch

Behaviour:
- Reset (reset=0, async): state=IDLE; acc=0, acc_valid=0, busy=0, count=0, overflow=0, internal len=0. prod_ready is 0 in reset.
- prod_ready = (state==ACCUM) && en; combinational from state and en only, never from prod_valid.
- Transfer occurs on a rising edge with prod_valid && prod_ready.
- en=0: no state, counter, or acc update; start and prod are ignored; outputs hold (acc_valid holds its current value).
- FSM states: IDLE, ACCUM, DONE.
  - IDLE: on start && en:
    - len!=0: acc<=0, count<=0, overflow<=0, latch len, go to ACCUM.
    - len==0: acc<=0, count<=0, overflow<=0, go straight to DONE (empty batch, sum 0).
  - ACCUM: on transfer: acc<=acc+sign_extend(prod), count<=count+1. If count+1==len, go to DONE. Otherwise stay in ACCUM.
  - DONE: acc_valid=1 for exactly one enabled cycle, then return to IDLE.
- acc_valid is registered and equals (state==DONE). Latency: last transfer at edge N -> acc_valid high in the cycle after edge N.
- acc, count, and overflow hold their values in IDLE until the next start.
- start while busy is ignored; there is no restart or abort.
- Overflow: signed ACC_W overflow on an add (operands same sign, result sign differs) sets overflow. It stays set until the next start or reset.
- Reset mid-batch: immediate return to IDLE with all outputs at reset values. Products in flight are dropped.
- A count that reaches the 2^CNT_W-1 maximum is legal with len=2^CNT_W-1. len is never exceeded.

Optional Feature:
ACC_SATURATE_EN
- Defined: on overflow, acc clamps to the most positive value (positive overflow) or the most negative value (negative overflow). Later adds operate on the clamped value. overflow is set as normal.
- Undefined: acc wraps modulo 2^ACC_W (two's complement). overflow is still set.

Test Plan:
- Reset: drive reset=0 mid-ACCUM after 2 transfers -> acc=0, count=0, busy=0, prod_ready=0, acc_valid=0 immediately (asynchronous).
- Basic batch: start, len=3; products 464960160, -143362716, 1348760118, each with prod_valid=1 -> acc=1670357562 and acc_valid=1 on the cycle after the 3rd transfer; count=3; overflow=0.
- Handshake stall: len=2; prod_valid gaps of 3 cycles and en=0 for 2 cycles mid-batch -> gaps and en=0 cycles accept nothing, prod_ready=0 while en=0; final acc = sum of the 2 accepted products (e.g. -1617244718460915990 + 67081 = -1617244718460848909).
- Empty batch and ignored start: start with len=0 -> acc=0, acc_valid pulse in the next cycle, count=0. A start pulse during ACCUM of another batch does not alter len, count, or acc.
- Overflow, built with ACC_W=64: two products of 64'h7FFF_FFFF_FFFF_FFFF.
  - Without the macro: acc=-2, overflow=1.
  - With ACC_SATURATE_EN: acc=64'h7FFF_FFFF_FFFF_FFFF, overflow=1.
  - A following start clears overflow to 0.
- Back-to-back batches: start reasserted in the IDLE cycle right after the acc_valid pulse, len=1, prod=0 -> second acc=0. The first batch's acc holds until that start edge.
